// File: rtl/game_flow_if.sv
// Signal bundle between the game sequencer and its neighbours (joystick_input,
// game_logic, VGA timing).
interface game_flow_if #(
  parameter int SCORE_W = 7
);
  // step_en and logic_clear are one-cycle strobes with no back-pressure: the
  // consumer must act on every high cycle, and step_dir is valid whenever
  // step_en is high (it is held unchanged between steps).
  logic               frame_tick;
  logic [1:0]         dir_in;
  logic               dir_valid;
  logic               pause_btn;
  logic               game_over_in;
  logic               game_won_in;
  logic [SCORE_W-1:0] score;
  logic               step_en;
  logic [1:0]         step_dir;
  logic               logic_clear;
  logic [2:0]         state;
  logic               blink;

  modport master (
    input  frame_tick, dir_in, dir_valid, pause_btn, game_over_in, game_won_in, score,
    output step_en, step_dir, logic_clear, state, blink
  );

  modport slave (
    output frame_tick, dir_in, dir_valid, pause_btn, game_over_in, game_won_in, score,
    input  step_en, step_dir, logic_clear, state, blink
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game sequencer: owns clear/idle/run/pause/over/won, paces game_logic steps in
// whole frames, filters direction reversals and speeds up as the score grows.
module game_flow_ctrl #(
  parameter int SCORE_W     = 7,
  parameter int BASE_PERIOD = 12,
  parameter int MIN_PERIOD  = 3,
  parameter int SPEEDUP_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  game_flow_if.master bus
);

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_OVER  = 3'd4,
    S_WON   = 3'd5
  } state_t;

  localparam int                 SHIFT = $clog2(SPEEDUP_DIV);
  localparam logic [SCORE_W-1:0] SPAN  = SCORE_W'(BASE_PERIOD - MIN_PERIOD);
  localparam logic [3:0]         BASE4 = 4'(BASE_PERIOD);
  localparam logic [3:0]         MIN4  = 4'(MIN_PERIOD);

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   period_q, period_d;
  logic [3:0]   bcnt_q, bcnt_d;
  logic [1:0]   pend_q, pend_d;
  logic [1:0]   sdir_q, sdir_d;
  logic         step_q, step_d;
  logic         clr_q, clr_d;
  logic         blink_q, blink_d;
  logic         pause_q;
  logic         pause_edge;
  logic         reversal;
  logic [SCORE_W-1:0] dec;
  logic [3:0]   new_period;

  assign pause_edge = bus.pause_btn && !pause_q;
  assign reversal   = (bus.dir_in == {sdir_q[1], ~sdir_q[0]});

  // Comparing before subtracting keeps the period from wrapping at high scores.
  assign dec        = bus.score >> SHIFT;
  assign new_period = (dec >= SPAN) ? MIN4 : (BASE4 - dec[3:0]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    bcnt_d   = bcnt_q;
    pend_d   = pend_q;
    sdir_d   = sdir_q;
    step_d   = 1'b0;
    clr_d    = 1'b0;
    blink_d  = 1'b0;
    case (state_q)
      // Out of reset CLEAR spends one cycle raising logic_clear; a restart
      // arrives with logic_clear already raised and leaves at once.
      S_CLEAR: begin
        if (clr_q) state_d = S_IDLE;
        else       clr_d   = 1'b1;
      end
      S_IDLE: begin
        if (bus.dir_valid) begin
          state_d  = S_RUN;
          pend_d   = bus.dir_in;
          sdir_d   = bus.dir_in;
          cnt_d    = 4'd0;
          period_d = new_period;
        end
      end
      S_RUN: begin
        bcnt_d = 4'd0;
        if (bus.game_over_in) begin
          state_d = S_OVER;
        end else if (bus.game_won_in) begin
          state_d = S_WON;
        end else if (pause_edge) begin
          state_d = S_PAUSE;
        end else begin
          if (bus.dir_valid && !reversal) pend_d = bus.dir_in;
          if (bus.frame_tick) begin
            if (cnt_q == period_q - 4'd1) begin
              step_d   = 1'b1;
              sdir_d   = pend_d;
              cnt_d    = 4'd0;
              period_d = new_period;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
      end
      S_PAUSE, S_OVER, S_WON: begin
        blink_d = blink_q;
        if (bus.frame_tick) begin
          bcnt_d = bcnt_q + 4'd1;
          if (bcnt_q == 4'd15) blink_d = ~blink_q;
        end
        if (pause_edge) begin
          blink_d = 1'b0;
          if (state_q == S_PAUSE) begin
            state_d = S_RUN;
          end else begin
            state_d = S_CLEAR;
            clr_d   = 1'b1;
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_CLEAR;
      cnt_q    <= 4'd0;
      period_q <= BASE4;
      bcnt_q   <= 4'd0;
      pend_q   <= 2'b00;
      sdir_q   <= 2'b00;
      step_q   <= 1'b0;
      clr_q    <= 1'b0;
      blink_q  <= 1'b0;
      pause_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      bcnt_q   <= bcnt_d;
      pend_q   <= pend_d;
      sdir_q   <= sdir_d;
      step_q   <= step_d;
      clr_q    <= clr_d;
      blink_q  <= blink_d;
      pause_q  <= bus.pause_btn;
    end
  end

  assign bus.step_en     = step_q;
  assign bus.step_dir    = sdir_q;
  assign bus.logic_clear = clr_q;
  assign bus.state       = state_q;
  assign bus.blink       = blink_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed tables and sequences plus a random phase,
// all cross-checked every cycle against a frame/tick-level reference model.
module tb_game_flow_ctrl;
  localparam int SCORE_W = 7;
  localparam int BASE = 12;
  localparam int MINP = 3;
  localparam int DIV  = 4;
  localparam int ST_CLEAR = 0, ST_IDLE = 1, ST_RUN = 2, ST_PAUSE = 3, ST_OVER = 4, ST_WON = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  game_flow_if #(.SCORE_W(SCORE_W)) bus();

  game_flow_ctrl #(
    .SCORE_W(SCORE_W), .BASE_PERIOD(BASE), .MIN_PERIOD(MINP), .SPEEDUP_DIV(DIV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- frame tick source ----------------
  logic auto_tick = 1'b0;
  logic man_tick = 1'b0;
  bit   tick_on = 1'b0;
  int   tick_gap = 10;
  int   tick_ctr = 0;
  assign bus.frame_tick = auto_tick | man_tick;

  always @(posedge clk) begin
    #1;
    if (tick_on && tick_ctr >= tick_gap - 1) begin
      auto_tick = 1'b1;
      tick_ctr  = 0;
    end else begin
      auto_tick = 1'b0;
      tick_ctr  = tick_on ? tick_ctr + 1 : 0;
    end
  end

  // ---------------- reference model ----------------
  function automatic int period_for(input int s);
    int p;
    p = BASE - s / DIV;
    return (p < MINP) ? MINP : p;
  endfunction

  function automatic bit is_reverse(input logic [1:0] a, input logic [1:0] b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

  bit         model_on = 1'b0;
  int         m_state, m_ticks_run, m_period, m_pause_ticks;
  logic [1:0] m_pend, m_dir;
  bit         m_step, m_clr, m_blink, m_btn_prev, m_press, m_was_clr;

  always @(posedge clk) begin
    if (reset) begin
      model_on = 1'b1;
      m_state = ST_CLEAR; m_step = 0; m_clr = 0; m_dir = 2'b00; m_pend = 2'b00;
      m_blink = 0; m_ticks_run = 0; m_pause_ticks = 0; m_btn_prev = 0; m_period = BASE;
    end else begin
      m_press    = bus.pause_btn && !m_btn_prev;
      m_btn_prev = bus.pause_btn;
      m_was_clr  = m_clr;
      m_step = 0;
      m_clr  = 0;
      case (m_state)
        ST_CLEAR: if (m_was_clr) m_state = ST_IDLE; else m_clr = 1;
        ST_IDLE: if (bus.dir_valid) begin
          m_state = ST_RUN; m_pend = bus.dir_in; m_dir = bus.dir_in;
          m_ticks_run = 0; m_period = period_for(int'(bus.score));
        end
        ST_RUN: begin
          m_pause_ticks = 0;
          if (bus.game_over_in) m_state = ST_OVER;
          else if (bus.game_won_in) m_state = ST_WON;
          else if (m_press) m_state = ST_PAUSE;
          else begin
            if (bus.dir_valid && !is_reverse(bus.dir_in, m_dir)) m_pend = bus.dir_in;
            if (bus.frame_tick) begin
              m_ticks_run++;
              if (m_ticks_run == m_period) begin
                m_step = 1; m_dir = m_pend; m_ticks_run = 0;
                m_period = period_for(int'(bus.score));
              end
            end
          end
        end
        default: begin
          if (m_press) begin
            m_blink = 0;
            if (m_state == ST_PAUSE) m_state = ST_RUN;
            else begin m_state = ST_CLEAR; m_clr = 1; end
          end else if (bus.frame_tick) begin
            m_pause_ticks++;
            if (m_pause_ticks % 16 == 0) m_blink = !m_blink;
          end
        end
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int         ticks_seen = 0;
  int         step_ticks[$];
  logic [1:0] dir_seen[$];
  logic [1:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.frame_tick === 1'b1) ticks_seen++;
    if (bus.step_en === 1'b1) begin
      step_ticks.push_back(ticks_seen);
      dir_seen.push_back(bus.step_dir);
    end
    if (model_on)
      check("model", {24'd0, bus.state, bus.step_en, bus.step_dir, bus.logic_clear, bus.blink},
            {24'd0, 3'(m_state), m_step, m_dir, m_clr, m_blink});
  end

  // ---------------- driver tasks ----------------
  task automatic clk_step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_steps(input int n, input string name);
    int target;
    int budget;
    target = step_ticks.size() + n;
    budget = 3000;
    while (step_ticks.size() < target && budget > 0) begin @(negedge clk); #1; budget--; end
    check({name, "_wait"}, step_ticks.size(), target);
  endtask

  task automatic wait_ticks_until(input int target, input string name);
    int budget;
    budget = 3000;
    while (ticks_seen < target && budget > 0) begin @(negedge clk); #1; budget--; end
    check({name, "_ticks"}, ticks_seen, target);
  endtask

  task automatic go_run(input logic [1:0] d);
    bus.dir_valid = 1'b1; bus.dir_in = d;
    clk_step();
    bus.dir_valid = 1'b0;
  endtask

  // ---------------- vector tables ----------------
  typedef struct { logic [1:0] a; bit two; logic [1:0] b; logic [1:0] exp_dir; } dir_vec_t;
  typedef struct { int score; int exp_period; } per_vec_t;
  dir_vec_t dir_tab[6];
  per_vec_t per_tab[8];

  int e0, p0, r0, n0, guard;

  initial begin
    dir_tab[0] = '{2'b10, 1'b0, 2'b00, 2'b11};
    dir_tab[1] = '{2'b00, 1'b0, 2'b00, 2'b00};
    dir_tab[2] = '{2'b01, 1'b0, 2'b00, 2'b00};
    dir_tab[3] = '{2'b10, 1'b1, 2'b11, 2'b11};
    dir_tab[4] = '{2'b00, 1'b1, 2'b10, 2'b00};
    dir_tab[5] = '{2'b10, 1'b1, 2'b01, 2'b10};
    per_tab[0] = '{0, 12};   per_tab[1] = '{8, 10};   per_tab[2] = '{36, 3};
    per_tab[3] = '{40, 3};   per_tab[4] = '{35, 4};   per_tab[5] = '{127, 3};
    per_tab[6] = '{4, 11};   per_tab[7] = '{3, 12};

    bus.dir_in = 2'b00; bus.dir_valid = 1'b0; bus.pause_btn = 1'b0;
    bus.game_over_in = 1'b0; bus.game_won_in = 1'b0; bus.score = '0;

    // 1: reset values, then a single logic_clear pulse
    reset = 1'b1;
    clk_step(3);
    check("rst_state", bus.state, ST_CLEAR);
    check("rst_clear", bus.logic_clear, 0);
    check("rst_step", bus.step_en, 0);
    check("rst_blink", bus.blink, 0);
    check("rst_dir", bus.step_dir, 0);
    reset = 1'b0;
    clk_step();
    check("t1_clear_hi", bus.logic_clear, 1);
    check("t1_state_clear", bus.state, ST_CLEAR);
    clk_step();
    check("t1_clear_lo", bus.logic_clear, 0);
    check("t1_state_idle", bus.state, ST_IDLE);

    // 2: run at base period with ticks every 10 cycles
    tick_gap = 10; tick_on = 1'b1;
    clk_step(2);
    go_run(2'b11);
    check("t2_state_run", bus.state, ST_RUN);
    e0 = ticks_seen;
    step_ticks.delete(); dir_seen.delete();
    wait_steps(3, "t2");
    check("t2_first", step_ticks[0] - e0, 12);
    check("t2_gap1", step_ticks[1] - step_ticks[0], 12);
    check("t2_gap2", step_ticks[2] - step_ticks[1], 12);
    for (int i = 0; i < 3; i++) exp_q.push_back(2'b11);
    for (int i = 0; i < 3; i++) check("t2_dir", dir_seen[i], exp_q.pop_front());

    // reset while step_en is high
    check("t2_step_hi", bus.step_en, 1);
    reset = 1'b1;
    clk_step();
    check("mid_rst_step", bus.step_en, 0);
    check("mid_rst_state", bus.state, ST_CLEAR);
    check("mid_rst_dir", bus.step_dir, 0);
    reset = 1'b0;
    clk_step();
    check("mid_rst_clear", bus.logic_clear, 1);
    clk_step();
    check("mid_rst_idle", bus.state, ST_IDLE);

    // 3: direction filter table
    tick_gap = 3;
    go_run(2'b11);
    wait_steps(1, "t3_entry");
    for (int i = 0; i < 6; i++) begin
      clk_step();
      bus.dir_valid = 1'b1; bus.dir_in = dir_tab[i].a;
      clk_step();
      if (dir_tab[i].two) begin bus.dir_in = dir_tab[i].b; clk_step(); end
      bus.dir_valid = 1'b0;
      wait_steps(1, "t3");
      exp_q.push_back(dir_tab[i].exp_dir);
      check($sformatf("t3_dir_row%0d", i), dir_seen[$], exp_q.pop_front());
    end

    // 4: period versus score table
    tick_gap = 2;
    for (int i = 0; i < 8; i++) begin
      bus.score = 7'(per_tab[i].score);
      wait_steps(3, "t4");
      check($sformatf("t4_period_s%0d", per_tab[i].score),
            step_ticks[$] - step_ticks[$-1], per_tab[i].exp_period);
    end

    // 5: pause mid-interval at count 5, blink, resume
    bus.score = '0; tick_gap = 10;
    wait_steps(2, "t5_sync");
    wait_ticks_until(step_ticks[$] + 5, "t5_count5");
    clk_step(2);
    bus.pause_btn = 1'b1;
    clk_step();
    check("t5_state_pause", bus.state, ST_PAUSE);
    p0 = ticks_seen; n0 = step_ticks.size();
    wait_ticks_until(p0 + 15, "t5_b15");
    clk_step();
    check("t5_blink_15", bus.blink, 0);
    wait_ticks_until(p0 + 16, "t5_b16");
    clk_step();
    check("t5_blink_16", bus.blink, 1);
    bus.pause_btn = 1'b0;
    wait_ticks_until(p0 + 32, "t5_b32");
    clk_step();
    check("t5_blink_32", bus.blink, 0);
    check("t5_no_steps", step_ticks.size(), n0);
    check("t5_still_pause", bus.state, ST_PAUSE);
    clk_step();
    bus.pause_btn = 1'b1;
    clk_step();
    check("t5_resume", bus.state, ST_RUN);
    check("t5_blink_off", bus.blink, 0);
    r0 = ticks_seen;
    wait_steps(1, "t5_resume");
    check("t5_resume_ticks", step_ticks[$] - r0, 7);
    bus.pause_btn = 1'b0;

    // 6: game over on a step-due tick, both flags, restart, won + blink
    bus.score = 7'd40; tick_gap = 2;
    wait_steps(3, "t6_sync");
    tick_on = 1'b0;
    clk_step(3);
    guard = 0;
    while ((ticks_seen - step_ticks[$]) != 2 && guard < 10) begin
      man_tick = 1'b1; clk_step(); man_tick = 1'b0; clk_step(2); guard++;
    end
    check("t6_align", ticks_seen - step_ticks[$], 2);
    n0 = step_ticks.size();
    man_tick = 1'b1; bus.game_over_in = 1'b1;
    clk_step();
    man_tick = 1'b0;
    check("t6_over_no_step", bus.step_en, 0);
    check("t6_over_state", bus.state, ST_OVER);
    bus.game_over_in = 1'b0;
    go_run(2'b00);
    clk_step(2);
    check("t6_over_hold", bus.state, ST_OVER);
    check("t6_over_steps", step_ticks.size(), n0);
    bus.pause_btn = 1'b1;
    clk_step();
    check("t6_restart_state", bus.state, ST_CLEAR);
    check("t6_restart_clear", bus.logic_clear, 1);
    clk_step();
    check("t6_restart_idle", bus.state, ST_IDLE);
    check("t6_restart_clear_lo", bus.logic_clear, 0);
    bus.pause_btn = 1'b0;
    go_run(2'b01);
    check("t6_run2", bus.state, ST_RUN);
    bus.game_over_in = 1'b1; bus.game_won_in = 1'b1;
    clk_step();
    check("t6_both_state", bus.state, ST_OVER);
    bus.game_over_in = 1'b0; bus.game_won_in = 1'b0;
    bus.pause_btn = 1'b1;
    clk_step(2);
    bus.pause_btn = 1'b0;
    go_run(2'b10);
    bus.game_won_in = 1'b1;
    clk_step();
    check("t6_won_state", bus.state, ST_WON);
    bus.game_won_in = 1'b0;
    tick_on = 1'b1;
    e0 = ticks_seen;
    wait_ticks_until(e0 + 16, "t6_won_blink");
    clk_step();
    check("t6_won_blink", bus.blink, 1);

    // random phase, checked cycle by cycle against the model
    for (int c = 0; c < 5000; c++) begin
      clk_step();
      if (reset) reset = ($urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
      else if ($urandom_range(0, 999) == 0) reset = 1'b1;
      bus.dir_valid    = ($urandom_range(0, 3) == 0);
      bus.dir_in       = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) bus.pause_btn = ~bus.pause_btn;
      bus.game_over_in = ($urandom_range(0, 399) == 0);
      bus.game_won_in  = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 99) == 0) bus.score = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 199) == 0) tick_gap = $urandom_range(2, 5);
    end
    reset = 1'b0;
    clk_step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
